// File: rtl/icache_arb_pkg.sv
// Shared constants, state encoding and helpers for the instruction-cache port arbiter.
package icache_arb_pkg;

    localparam int unsigned NUM_REQ = 32;
    localparam int unsigned SEL_W   = 5;
    localparam int unsigned TIMER_W = 8;
    localparam int unsigned TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } arb_state_e;

    // Decode a requester index into its one-hot requester vector.
    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin search: first set request bit strictly after rr_ptr, wrapping modulo NUM_REQ.
module rr_picker
    import icache_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   rr_ptr,
    output logic [SEL_W-1:0]   pick,
    output logic               any
);

    // The offset NUM_REQ wraps back onto rr_ptr itself, so it is searched last.
    always_comb begin
        pick = '0;
        any  = 1'b0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            if (!any && req[rr_ptr + SEL_W'(i)]) begin
                pick = rr_ptr + SEL_W'(i);
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/icache_port_arbiter.sv
// Round-robin sequencer of the shared ICache port among 32 fetch requesters,
// steering returning read data through the 32-way demultiplexer.
module icache_port_arbiter
    import icache_arb_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] err,
    output logic               cache_req,
    input  logic               cache_ack,
    input  logic               cache_rdata_valid,
    output logic [SEL_W-1:0]   demux_selection,
    output logic               demux_enable,
    output logic               busy
);

    arb_state_e         state, state_nxt;
    logic [SEL_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [SEL_W-1:0]   cur, cur_nxt;
    logic [TIMER_W-1:0] timer, timer_nxt;
    logic [SEL_W-1:0]   sel_nxt;
    logic [SEL_W-1:0]   pick;
    logic               any;

    rr_picker u_picker (
        .req    (req),
        .rr_ptr (rr_ptr),
        .pick   (pick),
        .any    (any)
    );

    // rr_ptr resets to the last index so requester 0 wins the first search.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            rr_ptr          <= SEL_W'(NUM_REQ - 1);
            cur             <= '0;
            timer           <= '0;
            demux_selection <= '0;
        end else begin
            state           <= state_nxt;
            rr_ptr          <= rr_ptr_nxt;
            cur             <= cur_nxt;
            timer           <= timer_nxt;
            demux_selection <= sel_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        cur_nxt      = cur;
        timer_nxt    = timer;
        sel_nxt      = demux_selection;
        grant        = '0;
        done         = '0;
        err          = '0;
        cache_req    = 1'b0;
        demux_enable = 1'b0;

        case (state)
            IDLE: begin
                if (any) begin
                    cur_nxt    = pick;
                    rr_ptr_nxt = pick;
                    state_nxt  = REQ;
                end
            end

            // An ack in the same cycle as a request drop still commits the fetch.
            REQ: begin
                grant     = onehot(cur);
                cache_req = 1'b1;
                if (cache_ack) begin
                    state_nxt = WAIT;
                    timer_nxt = '0;
                    sel_nxt   = cur;
                end else if (!req[cur]) begin
                    state_nxt = IDLE;
                end
            end

            // Data on the final timeout cycle still counts as a successful delivery.
            WAIT: begin
                grant        = onehot(cur);
                demux_enable = cache_rdata_valid;
                if (cache_rdata_valid) begin
                    done      = onehot(cur);
                    state_nxt = IDLE;
                end else if (timer == TIMER_W'(TIMEOUT)) begin
                    err       = onehot(cur);
                    state_nxt = DRAIN;
                end else begin
                    timer_nxt = timer + TIMER_W'(1);
                end
            end

            // Swallow the late response of an abandoned fetch.
            DRAIN: begin
                if (cache_rdata_valid) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_icache_port_arbiter.sv
// Directed bench for icache_port_arbiter with a cycle-level transaction model checked every cycle.
`timescale 1ns/1ps
module tb_icache_port_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] req;
    logic [31:0] grant;
    logic [31:0] done;
    logic [31:0] err;
    logic        cache_req;
    logic        cache_ack;
    logic        cache_rdata_valid;
    logic [4:0]  demux_selection;
    logic        demux_enable;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    icache_port_arbiter dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .req               (req),
        .grant             (grant),
        .done              (done),
        .err               (err),
        .cache_req         (cache_req),
        .cache_ack         (cache_ack),
        .cache_rdata_valid (cache_rdata_valid),
        .demux_selection   (demux_selection),
        .demux_enable      (demux_enable),
        .busy              (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: phase 0 idle, 1 address phase, 2 data wait, 3 draining.
    int m_phase = 0;
    int m_owner = 0;
    int m_last  = 31;
    int m_wait  = 0;
    int m_sel   = 0;

    always @(negedge clock) begin : model_cmp
        logic [31:0] own;
        logic [31:0] e_grant;
        logic [31:0] e_done;
        logic [31:0] e_err;
        logic        found;
        if (!reset_n) begin
            m_phase = 0;
            m_owner = 0;
            m_last  = 31;
            m_wait  = 0;
            m_sel   = 0;
        end
        own     = 32'd1 << m_owner;
        e_grant = (m_phase == 1 || m_phase == 2) ? own : 32'd0;
        e_done  = (m_phase == 2 && cache_rdata_valid) ? own : 32'd0;
        e_err   = (m_phase == 2 && !cache_rdata_valid && m_wait == 255) ? own : 32'd0;

        chk("m_grant", grant, e_grant);
        chk("m_done", done, e_done);
        chk("m_err", err, e_err);
        chk("m_cache_req", 32'(cache_req), 32'(m_phase == 1));
        chk("m_demux_en", 32'(demux_enable), 32'(m_phase == 2 && cache_rdata_valid));
        chk("m_demux_sel", 32'(demux_selection), 32'(m_sel));
        chk("m_busy", 32'(busy), 32'(m_phase != 0));
        chk("inv_grant_onehot0", 32'($countones(grant) <= 1), 32'd1);
        chk("inv_done_err_excl", 32'(|(done & err)), 32'd0);

        if (reset_n) begin
            case (m_phase)
                0: if (req != 32'd0) begin
                    found = 1'b0;
                    for (int k = 1; k <= 32; k++) begin
                        if (!found && req[(m_last + k) % 32]) begin
                            m_owner = (m_last + k) % 32;
                            found   = 1'b1;
                        end
                    end
                    m_last  = m_owner;
                    m_phase = 1;
                end
                1: if (cache_ack) begin
                    m_phase = 2;
                    m_wait  = 0;
                    m_sel   = m_owner;
                end else if (!req[m_owner]) begin
                    m_phase = 0;
                end
                2: if (cache_rdata_valid) m_phase = 0;
                   else if (m_wait == 255) m_phase = 3;
                   else m_wait++;
                default: if (cache_rdata_valid) m_phase = 0;
            endcase
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n           = 1'b0;
        req               = '0;
        cache_ack         = 1'b0;
        cache_rdata_valid = 1'b0;
        cyc();
        cyc();
        reset_n = 1'b1;
    endtask

    // Runs one fetch starting in an idle cycle with req already set; returns in the next idle cycle.
    task automatic txn(input int exp_idx, input int rdelay);
        logic [31:0] exp_oh;
        exp_oh = 32'd1 << exp_idx;
        @(negedge clock);
        chk("txn_bubble_busy", 32'(busy), 32'd0);
        cyc();
        cache_ack = 1'b1;
        @(negedge clock);
        chk("txn_grant", grant, exp_oh);
        cyc();
        cache_ack = 1'b0;
        repeat (rdelay) begin
            @(negedge clock);
            cyc();
        end
        cache_rdata_valid = 1'b1;
        @(negedge clock);
        chk("txn_done", done, exp_oh);
        chk("txn_sel", 32'(demux_selection), 32'(exp_idx));
        cyc();
        cache_rdata_valid = 1'b0;
    endtask

    initial begin
        // Reset state and the single uncontended fetch
        do_reset();
        @(negedge clock);
        chk("rst_grant", grant, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sel", 32'(demux_selection), 32'd0);
        chk("rst_cache_req", 32'(cache_req), 32'd0);
        cyc();
        req = 32'h0000_0001;
        @(negedge clock);
        chk("t1_c0_busy", 32'(busy), 32'd0);
        cyc();
        cache_ack = 1'b1;
        @(negedge clock);
        chk("t1_c1_cache_req", 32'(cache_req), 32'd1);
        chk("t1_c1_grant", grant, 32'h0000_0001);
        cyc();
        cache_ack = 1'b0;
        @(negedge clock);
        chk("t1_c2_done", done, 32'd0);
        chk("t1_c2_demux_en", 32'(demux_enable), 32'd0);
        cyc();
        cache_rdata_valid = 1'b1;
        @(negedge clock);
        chk("t1_c3_demux_en", 32'(demux_enable), 32'd1);
        chk("t1_c3_sel", 32'(demux_selection), 32'd0);
        chk("t1_c3_done", done, 32'h0000_0001);
        chk("t1_c3_err", err, 32'd0);
        cyc();
        cache_rdata_valid = 1'b0;
        req = 32'd0;
        @(negedge clock);
        chk("t1_c4_busy", 32'(busy), 32'd0);
        cyc();

        // All requesters contending: strict rotation 0..31 then 0 again
        do_reset();
        req = 32'hFFFF_FFFF;
        for (int n = 0; n <= 32; n++) txn(n % 32, 0);
        req = 32'd0;

        // Pointer at 5 with requesters 3 and 30: 30 first, then 3
        do_reset();
        req = 32'd1 << 5;
        txn(5, 1);
        req = (32'd1 << 3) | (32'd1 << 30);
        txn(30, 2);
        txn(3, 0);
        req = 32'd0;

        // Abort: requester 7 withdraws before the ack
        req = 32'd1 << 7;
        @(negedge clock);
        cyc();
        req = 32'd0;
        @(negedge clock);
        chk("ab_cache_req", 32'(cache_req), 32'd1);
        chk("ab_grant", grant, 32'h0000_0080);
        cyc();
        @(negedge clock);
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_grant_idle", grant, 32'd0);
        chk("ab_done", done, 32'd0);
        chk("ab_err", err, 32'd0);
        cyc();

        // Timeout on requester 12, then a late response 10 cycles after the error
        req = 32'd1 << 12;
        @(negedge clock);
        cyc();
        cache_ack = 1'b1;
        @(negedge clock);
        chk("to_grant", grant, 32'h0000_1000);
        cyc();
        cache_ack = 1'b0;
        repeat (255) begin
            @(negedge clock);
            cyc();
        end
        @(negedge clock);
        chk("to_err", err, 32'h0000_1000);
        chk("to_done", done, 32'd0);
        cyc();
        req = 32'd0;
        @(negedge clock);
        chk("dr_grant", grant, 32'd0);
        chk("dr_busy", 32'(busy), 32'd1);
        cyc();
        repeat (8) begin
            @(negedge clock);
            cyc();
        end
        cache_rdata_valid = 1'b1;
        @(negedge clock);
        chk("late_demux_en", 32'(demux_enable), 32'd0);
        chk("late_done", done, 32'd0);
        chk("late_busy", 32'(busy), 32'd1);
        cyc();
        cache_rdata_valid = 1'b0;
        @(negedge clock);
        chk("late_idle", 32'(busy), 32'd0);
        cyc();

        // Asynchronous reset in the middle of a data wait
        req = 32'd1 << 9;
        @(negedge clock);
        cyc();
        cache_ack = 1'b1;
        @(negedge clock);
        cyc();
        cache_ack = 1'b0;
        @(negedge clock);
        chk("ar_wait_grant", grant, 32'h0000_0200);
        chk("ar_wait_sel", 32'(demux_selection), 32'd9);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_grant", grant, 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_cache_req", 32'(cache_req), 32'd0);
        chk("ar_demux_en", 32'(demux_enable), 32'd0);
        chk("ar_sel", 32'(demux_selection), 32'd0);
        req = 32'hFFFF_FFFF;
        cyc();
        cyc();
        reset_n = 1'b1;
        txn(0, 0);
        req = 32'd0;
        @(negedge clock);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/icache_port_arbiter.md
Name: icache_port_arbiter

Overview:
- Sequences the shared 4 KB instruction-cache port among 32 fetch requesters (tp0..tp31).
- Grants one requester at a time, round-robin; the granted requester drives the wired-OR address bus.
- Issues the cache request and waits for read data.
- Drives the 5-bit selection and enable of the 32-way read-data demultiplexer, so returning data reaches only the granted requester.

Parameters:
- NUM_REQ, 32, number of requesters; fixed to 32 by the demux width.
- SEL_W, 5, width of the requester index (log2 NUM_REQ).
- TIMEOUT, 255, maximum cycles in WAIT before the transaction is abandoned; 8-bit counter.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  32  per-requester fetch request; level; held until done or abort.
- grant  out  32  one-hot; the granted requester may drive the address bus.
- done  out  32  one-hot, 1-cycle pulse: the data for that requester is on the demux output this cycle.
- err  out  32  one-hot, 1-cycle pulse: the requester's transaction timed out.
- cache_req  out  1  request to the ICache.
- cache_ack  in  1  the ICache accepted the address (1-cycle pulse).
- cache_rdata_valid  in  1  the ICache read data is valid (1-cycle pulse).
- demux_selection  out  5  index driven to the demultiplexer selection input.
- demux_enable  out  1  enable driven to the demultiplexer.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE; rr_ptr=31, so requester 0 has first priority.
  - grant, done, err = 0; cache_req=0; demux_enable=0; demux_selection=0; timer=0.
  - Reset mid-transaction drops everything. No done or err is generated for the dropped transaction.
- Registers: state, rr_ptr[4:0], cur[4:0], timer[7:0].
- Round-robin pick: the first set bit of req searching upward from rr_ptr+1, wrapping modulo 32.
- IDLE:
  - If req != 0: cur <= pick, rr_ptr <= pick, go REQ.
  - Else stay in IDLE.
- REQ:
  - grant[cur]=1; cache_req=1.
  - cache_ack=1 → go WAIT, timer <= 0.
  - req[cur]=0 and no cache_ack → abort: go IDLE, no done or err. rr_ptr stays updated, for fairness.
  - cache_ack and req drop in the same cycle: the ack wins, go WAIT.
- WAIT:
  - grant[cur] stays 1; cache_req=0.
  - demux_selection=cur, held stable throughout WAIT.
  - demux_enable = cache_rdata_valid, combinational in this state only.
  - done[cur] = cache_rdata_valid, the same cycle; then go IDLE.
  - A drop of req[cur] in WAIT is ignored; the data is still delivered.
  - Otherwise timer increments each cycle.
  - timer==TIMEOUT with no rdata_valid → err[cur] pulse the same cycle, go DRAIN.
  - rdata_valid on the TIMEOUT cycle counts as success: done, no err.
- DRAIN:
  - grant=0; demux_enable=0.
  - Wait for the late cache_rdata_valid, discard it, then go IDLE.
  - The ICache guarantees an eventual response.
- Latency, uncontended: req high at cycle N → cache_req at N+1 → ack at N+1 (earliest) → done at N+2 (earliest).
- Back-to-back: from the done cycle → IDLE → next REQ, so there is a 1-cycle bubble between transactions.
- Outside WAIT, demux_selection holds its last value and demux_enable=0.
  - The demux therefore outputs all zeros, keeping the wired-OR return bus clean.
- Invariants:
  - grant is 0 or one-hot.
  - done and err are never asserted together.
  - A requester never sees two grants in a row while any other req bit is set.

Decomposition:
- Package icache_arb_pkg holds:
  - the NUM_REQ, SEL_W and TIMEOUT defaults;
  - the state enum: IDLE, REQ, WAIT, DRAIN (2 bits);
  - the one-hot decode helper function.
- Sub-module rr_picker: combinational; inputs req[31:0] and rr_ptr[4:0]; outputs pick[4:0] and any.
  - The picker is instantiated once and is verified standalone.

Test Plan:
- Reset with req=32'h0000_0001 → pick idx0. cache_req at cycle 1; ack at cycle 1; rdata_valid at cycle 3 → demux_enable=1, demux_selection=0, done=32'h1 at cycle 3. No err.
- req=32'hFFFF_FFFF held, immediate ack and rdata each transaction → grants in order 0,1,2,…,31,0. Each done is one-hot, with a 1-cycle bubble between transactions.
- rr_ptr=5 with req bits 3 and 30 set → the grant goes to 30, then to 3.
- Abort: req[7] drops in REQ before ack → IDLE next cycle. done=0, err=0, demux_enable never high.
- Timeout: ack given, no rdata for 256 cycles → err=32'h…(bit cur) pulse, DRAIN. A late rdata_valid 10 cycles later → demux_enable stays 0, done=0, then IDLE.
- Async reset asserted mid-WAIT → all outputs 0 immediately. After release, requester 0 is granted first.
